reg_wb_arbiter: RTL and testbench

- Arbitrates the single register-file write port between three writeback sources:
  - MEM: load results.
  - ALU: results, buffered in a FIFO.
  - RA: link writes to the return-address register.
- Issues at most one registered write per cycle into the register file's writable/write_addr/write_value port.
- Keeps a pending-write scoreboard so decode can stall reads of registers whose writes have not yet been issued.

---
 rtl/reg_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter for MEM, buffered ALU and RA sources, with a pending-write stall scoreboard.
// Latency: MEM/ALU one cycle to wb_*; RA one cycle after it becomes pending. Issue order: MEM, promoted RA, FIFO head, ALU bypass, RA.
// Backpressure: alu_ready is a pure not-full check, ra_ready drops while RA is pending, and MEM is never stalled.
module reg_wb_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int FIFO_DEPTH  = 2,
    parameter int RA_ADDR     = 13,
    parameter int RA_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_value,
    input  logic              alu_req,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_value,
    output logic              alu_ready,
    input  logic              ra_req,
    input  logic [DATA_W-1:0] ra_value,
    output logic              ra_ready,
    input  logic              readable1,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic              readable2,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic              stall,
    output logic              wb_writable,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_value
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(RA_MAX_WAIT + 1);
    localparam int NREG   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(RA_MAX_WAIT);
    localparam logic [ADDR_W-1:0] RA_A     = ADDR_W'(RA_ADDR);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] value;
    } wr_t;

    typedef enum logic [2:0] {SEL_NONE, SEL_MEM, SEL_RA, SEL_FIFO, SEL_BYP} sel_t;

    wr_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ra_pending;
    logic [DATA_W-1:0] ra_value_q;
    logic [WAIT_W-1:0] ra_wait;
    logic              fifo_empty;
    logic              alu_acc;
    logic              mem_win;
    logic              ra_promote;
    logic              push;
    logic              pop;
    sel_t              sel;
    logic [NREG-1:0]   pending;
    logic [FIFO_DEPTH-1:0] slot_vld;

    assign fifo_empty = (count == '0);
    assign alu_ready  = (count != DEPTH_C);
    assign ra_ready   = !ra_pending;
    // Address-0 requests complete the handshake but are otherwise ignored.
    assign alu_acc    = alu_req && alu_ready && (alu_addr != '0);
    assign mem_win    = mem_req && (mem_addr != '0);
    assign ra_promote = ra_pending && (ra_wait >= WAIT_MAX);

    always_comb begin
        sel = SEL_NONE;
        if (mem_win)          sel = SEL_MEM;
        else if (ra_promote)  sel = SEL_RA;
        else if (!fifo_empty) sel = SEL_FIFO;
        else if (alu_acc)     sel = SEL_BYP;
        else if (ra_pending)  sel = SEL_RA;
    end

    assign push = alu_acc && (sel != SEL_BYP);
    assign pop  = (sel == SEL_FIFO);

    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_slot
        logic [PTR_W-1:0] off;
        assign off         = PTR_W'(g) - rd_ptr;
        assign slot_vld[g] = ({1'b0, off} < count);
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_vld[i]) pending[fifo_mem[i].addr] = 1'b1;
        end
        if (ra_pending) pending[RA_A] = 1'b1;
        pending[0] = 1'b0;
    end

    assign stall = (readable1 && pending[read_addr1]) || (readable2 && pending[read_addr2]);

    always_ff @(posedge clk) begin
        if (rst && push) fifo_mem[wr_ptr] <= '{addr: alu_addr, value: alu_value};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ra_pending  <= 1'b0;
            ra_value_q  <= '0;
            ra_wait     <= '0;
            wb_writable <= 1'b0;
            wb_addr     <= '0;
            wb_value    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            wb_writable <= (sel != SEL_NONE);
            unique case (sel)
                SEL_MEM: begin
                    wb_addr  <= mem_addr;
                    wb_value <= mem_value;
                end
                SEL_RA: begin
                    wb_addr    <= RA_A;
                    wb_value   <= ra_value_q;
                    ra_pending <= 1'b0;
                    ra_wait    <= '0;
                end
                SEL_FIFO: begin
                    wb_addr  <= fifo_mem[rd_ptr].addr;
                    wb_value <= fifo_mem[rd_ptr].value;
                end
                SEL_BYP: begin
                    wb_addr  <= alu_addr;
                    wb_value <= alu_value;
                end
                default: ;
            endcase

            // Only ALU wins age a pending RA; MEM wins never promote it.
            if (ra_pending && (sel == SEL_FIFO || sel == SEL_BYP) && ra_wait < WAIT_MAX)
                ra_wait <= ra_wait + WAIT_W'(1);

            if (ra_req && ra_ready) begin
                ra_pending <= 1'b1;
                ra_value_q <= ra_value;
            end
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized plus directed bench for reg_wb_arbiter; a queue-based reference model predicts every register-file write.
module tb_reg_wb_arbiter;
    localparam int DW = 16, AW = 4, DEPTH = 2, RA_A = 13, MAXW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, mem_req, alu_req, ra_req, readable1, readable2;
    logic [AW-1:0] mem_addr, alu_addr, read_addr1, read_addr2;
    logic [DW-1:0] mem_value, alu_value, ra_value;
    logic          alu_ready, ra_ready, stall, wb_writable;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_value;

    reg_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RA_ADDR(RA_A), .RA_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_value(mem_value),
        .alu_req(alu_req), .alu_addr(alu_addr), .alu_value(alu_value), .alu_ready(alu_ready),
        .ra_req(ra_req), .ra_value(ra_value), .ra_ready(ra_ready),
        .readable1(readable1), .read_addr1(read_addr1), .readable2(readable2), .read_addr2(read_addr2),
        .stall(stall), .wb_writable(wb_writable), .wb_addr(wb_addr), .wb_value(wb_value)
    );

    typedef struct {
        int unsigned addr;
        int unsigned value;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0, bad = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;

    int unsigned m_q_addr[$], m_q_val[$];
    bit          m_ra_pend;
    int unsigned m_ra_val;
    int          m_wait;
    bit          last_alu_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit m_pending(input int unsigned r);
        if (r == 0) return 1'b0;
        foreach (m_q_addr[i]) if (m_q_addr[i] == r) return 1'b1;
        return m_ra_pend && (r == RA_A);
    endfunction

    // One clock of stimulus: drive, check combinational outputs, advance the model.
    task automatic step(input bit rstv, input bit mreq, input int unsigned maddr, input int unsigned mval,
                        input bit areq, input int unsigned aaddr, input int unsigned aval,
                        input bit rreq, input int unsigned rval,
                        input bit re1, input int unsigned ra1, input bit re2, input int unsigned ra2);
        bit acc, keep, issued, old_pend;
        int unsigned ia, iv;
        maddr &= 15; aaddr &= 15; ra1 &= 15; ra2 &= 15;
        mval &= 16'hFFFF; aval &= 16'hFFFF; rval &= 16'hFFFF;
        @(negedge clk);
        rst = rstv; mem_req = mreq; mem_addr = AW'(maddr); mem_value = DW'(mval);
        alu_req = areq; alu_addr = AW'(aaddr); alu_value = DW'(aval);
        ra_req = rreq; ra_value = DW'(rval);
        readable1 = re1; read_addr1 = AW'(ra1); readable2 = re2; read_addr2 = AW'(ra2);
        #1;
        check("alu_ready", alu_ready, m_q_addr.size() < DEPTH);
        check("ra_ready", ra_ready, !m_ra_pend);
        check("stall", stall, (re1 && m_pending(ra1)) || (re2 && m_pending(ra2)));

        acc = areq && (m_q_addr.size() < DEPTH);
        if (!rstv) begin
            m_q_addr.delete(); m_q_val.delete();
            m_ra_pend = 0; m_wait = 0; last_alu_acc = 0;
            return;
        end
        last_alu_acc = acc;
        keep = acc && (aaddr != 0);
        old_pend = m_ra_pend;
        issued = 0; ia = 0; iv = 0;
        if (mreq && maddr != 0) begin
            issued = 1; ia = maddr; iv = mval;
        end else if (m_ra_pend && m_wait >= MAXW) begin
            issued = 1; ia = RA_A; iv = m_ra_val; m_ra_pend = 0; m_wait = 0;
        end else if (m_q_addr.size() > 0) begin
            issued = 1; ia = m_q_addr.pop_front(); iv = m_q_val.pop_front();
            if (m_ra_pend && m_wait < MAXW) m_wait++;
        end else if (keep) begin
            issued = 1; ia = aaddr; iv = aval; keep = 0;
            if (m_ra_pend && m_wait < MAXW) m_wait++;
        end else if (m_ra_pend) begin
            issued = 1; ia = RA_A; iv = m_ra_val; m_ra_pend = 0; m_wait = 0;
        end
        if (keep) begin
            m_q_addr.push_back(aaddr); m_q_val.push_back(aval);
        end
        if (rreq && !old_pend) begin
            m_ra_pend = 1; m_ra_val = rval;
        end
        if (issued) exp_q.push_back('{ia, iv, cyc + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, RA_A);
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        mem_req = 0; alu_req = 0; ra_req = 0;
        readable1 = 1; read_addr1 = 6; readable2 = 1; read_addr2 = AW'(RA_A);
        #1;
        check("rst_wb_writable", wb_writable, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_value", wb_value, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_ra_ready", ra_ready, 1);
        check("rst_stall", stall, 0);
    endtask

    // Monitor: every write on wb_* must match the next predicted write, on the predicted cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (wb_writable) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL wb_spurious: got write addr %0h value %0h, want no write (cycle %0d)", wb_addr, wb_value, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_cycle", cyc, e.cyc);
                        check("wb_addr", wb_addr, e.addr);
                        check("wb_value", wb_value, e.value);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    total++; bad++;
                    $display("FAIL wb_missing: got no write, want addr %0h value %0h (cycle %0d)", e.addr, e.value, cyc);
                end
            end
        end
    end

    initial begin
        int unsigned vals[3];
        int idx;
        rst = 0; mem_req = 0; alu_req = 0; ra_req = 0; readable1 = 0; readable2 = 0;
        mem_addr = 0; alu_addr = 0; read_addr1 = 0; read_addr2 = 0;
        mem_value = 0; alu_value = 0; ra_value = 0;
        m_ra_pend = 0; m_wait = 0; m_ra_val = 0; last_alu_acc = 0;
        repeat (3) @(posedge clk);
        check_reset_state();
        mon_en = 1'b1;

        // 1: single uncontended ALU write
        step(1, 0, 0, 0, 1, 3, 16'h1234, 0, 0, 1, 3, 0, 0);
        idle(2);

        // 2: MEM holds the port while the ALU FIFO fills; third value retries until accepted
        vals[0] = 16'h000A; vals[1] = 16'h000B; vals[2] = 16'h000C; idx = 0;
        for (int i = 0; i < 9; i++) begin
            step(1, i < 4, 5, 16'h5000 + i, idx < 3, 6, (idx < 3) ? vals[idx] : 0, 0, 0, 1, 6, 0, 0);
            if (last_alu_acc) idx++;
        end
        idle(2);

        // 3: RA link write with the FIFO empty
        step(1, 0, 0, 0, 0, 0, 0, 1, 16'h00FF, 0, 0, 1, RA_A);
        idle(3);

        // 4: RA starved by ALU until promoted
        step(1, 0, 0, 0, 1, 1, 16'h4000, 1, 16'h0BEE, 0, 0, 1, RA_A);
        for (int i = 1; i < 9; i++) step(1, 0, 0, 0, 1, 1 + (i % 5), 16'h4000 + i, 0, 0, 1, 2, 1, RA_A);
        idle(4);

        // 5: address-0 requests are dropped
        step(1, 1, 0, 16'hDEAD, 1, 0, 16'hBEEF, 0, 0, 1, 0, 1, 0);
        idle(2);

        // 6: reset with a full FIFO and RA pending discards everything
        step(1, 1, 5, 16'h0055, 1, 7, 16'h0071, 1, 16'h0077, 1, 7, 0, 0);
        step(1, 1, 5, 16'h0056, 1, 8, 16'h0081, 0, 0, 1, 8, 1, RA_A);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, RA_A);
        check_reset_state();
        idle(4);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
                 $urandom_range(0, 2) == 0, $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                 ($urandom_range(0, 1) != 0) ? RA_A : $urandom_range(0, 15));
        end
        idle(4);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL wb_drain: got %0d writes never issued, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
